// File: rtl/branch_cond_unit.sv
// branch_cond_unit: flag file with same-cycle forwarding, 16-way branch
// condition evaluation, registered taken pulse and multi-cycle flush sequencer.
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_cond_unit #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flag_we,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_ovf,
    input  logic              br_valid,
    input  logic [3:0]        BS,
    input  logic              stall,
    output logic              MP,
    output logic              flush,
    output logic              br_busy,
`ifdef BRANCH_STATS_EN
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  taken_count,
`endif
    output logic [3:0]        flags_q
);

    localparam int unsigned FC_W = 4;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    // Reject parameter values outside the supported range at elaboration
    generate
        if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15 || CNT_W < 1 || DATA_W < 1) begin : g_param_check
            $error("branch_cond_unit: illegal parameter value");
        end
    endgenerate

    state_t            state_q, state_d;
    logic [FC_W-1:0]   cnt_q, cnt_d;
    logic              mp_d, flush_d;
    logic [3:0]        flags_new_c;
    logic [3:0]        flags_eff_c;
    logic              cond_c;
    logic              accept_c;
    logic              taken_c;

    // Flags derived from the ALU this cycle and the forwarded view used for evaluation
    always_comb begin
        flags_new_c = {(alu_result == '0), alu_result[DATA_W-1], alu_carry, alu_ovf};
        flags_eff_c = flag_we ? flags_new_c : flags_q;
    end

    // Branch condition decode over effective {Z,N,C,V}
    always_comb begin
        logic z, n, c, v;
        z      = flags_eff_c[3];
        n      = flags_eff_c[2];
        c      = flags_eff_c[1];
        v      = flags_eff_c[0];
        cond_c = 1'b0;
        case (BS)
            4'd0:  cond_c = z;
            4'd1:  cond_c = ~z;
            4'd2:  cond_c = ~n;
            4'd3:  cond_c = n;
            4'd4:  cond_c = 1'b0;
            4'd5:  cond_c = 1'b1;
            4'd6:  cond_c = c;
            4'd7:  cond_c = ~c;
            4'd8:  cond_c = v;
            4'd9:  cond_c = ~v;
            4'd10: cond_c = ~z & (n ~^ v);
            4'd11: cond_c = z | (n ^ v);
            4'd12: cond_c = n ~^ v;
            4'd13: cond_c = n ^ v;
            4'd14: cond_c = c & ~z;
            4'd15: cond_c = ~c | z;
            default: cond_c = 1'b0;
        endcase
    end

    // Next-state, flush counter and registered-output next values
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mp_d     = 1'b0;
        accept_c = 1'b0;
        taken_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (br_valid && !stall) begin
                    accept_c = 1'b1;
                    if (cond_c) begin
                        taken_c = 1'b1;
                        mp_d    = 1'b1;
                        state_d = S_FLUSH;
                        cnt_d   = FC_W'(FLUSH_CYCLES - 1);
                    end
                end
            end
            S_FLUSH: begin
                if (!stall) begin
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - FC_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        flush_d = (state_d == S_FLUSH);
    end

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            MP      <= 1'b0;
            flush   <= 1'b0;
            br_busy <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            MP      <= mp_d;
            flush   <= flush_d;
            br_busy <= flush_d;
        end
    end

    // Flag file capture; held while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 4'b0000;
        end else if (flag_we && !stall) begin
            flags_q <= flags_new_c;
        end
    end

`ifdef BRANCH_STATS_EN
    // Saturating branch statistics; accept/taken already exclude stalled cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            br_count    <= '0;
            taken_count <= '0;
        end else begin
            if (accept_c && (br_count != '1)) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (taken_c && (taken_count != '1)) begin
                taken_count <= taken_count + CNT_W'(1);
            end
        end
    end
`else
    // Accept/taken strobes only feed the optional statistics counters
    logic unused_stats_c;
    assign unused_stats_c = accept_c ^ taken_c;
`endif

endmodule

// File: doc/branch_cond_unit.md
Name: branch_cond_unit

Overview:
- Parametrised successor to the combinational branch-select mux; sits between the ALU and the PC-select logic of the pipelined datapath.
- Holds a registered Z/N/C/V flag file, forwards same-cycle flag writes, and evaluates a 4-bit branch-select code (16 conditions, including signed and unsigned compares).
- Issues a registered taken pulse and sequences a multi-cycle pipeline flush for squashing wrong-path instructions.

Parameters:
- DATA_W, 16, width of the ALU result used to derive Z/N.
- FLUSH_CYCLES, 2, cycles flush stays asserted after a taken branch; legal range 1..15.
- CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- flag_we  input  1  capture flags from the ALU this cycle.
- alu_result  input  DATA_W  ALU result; Z = (alu_result==0), N = alu_result[DATA_W-1].
- alu_carry  input  1  ALU carry-out (C).
- alu_ovf  input  1  ALU signed overflow (V).
- br_valid  input  1  a branch instruction is presented this cycle.
- BS  input  4  branch-select code.
- stall  input  1  pipeline stall; freezes all state.
- MP  output  1  branch-taken pulse (PC mux select), registered.
- flush  output  1  squash younger pipeline stages.
- br_busy  output  1  unit is in the flush sequence; new branches are ignored.
- flags_q  output  4  registered flags {Z,N,C,V}.

Behaviour:
- Reset: all outputs 0; flags_q = 4'b0000; FSM in IDLE; flush counter = 0.
- Flag register: on flag_we & ~stall, flags_q <= {Z,N,C,V} computed from the inputs at that edge. Otherwise flags_q holds.
- Forwarding: evaluation uses the effective flags. These are the new input-derived flags when flag_we=1 in the same cycle, else flags_q. Forwarding applies even when stall=1.
- BS codes (Z,N,C,V = effective flags):
  - 0 EQ = Z; 1 NE = ~Z; 2 GEZ = ~N; 3 LTZ = N; 4 NEVER = 0; 5 ALWAYS = 1.
  - 6 CS = C; 7 CC = ~C; 8 VS = V; 9 VC = ~V.
  - 10 GT = ~Z&(N~^V); 11 LE = Z|(N^V); 12 GE = N~^V; 13 LT = N^V.
  - 14 HI = C&~Z; 15 LS = ~C|Z.
  - Codes 0-4 are bit-compatible with the previous 3-bit encoding zero-extended.
- FSM states: IDLE, FLUSH.
  - IDLE: a branch is accepted when br_valid & ~stall. Accepted and condition true -> next cycle MP=1 (exactly one cycle), flush=1, br_busy=1, counter loaded with FLUSH_CYCLES-1, state -> FLUSH. Accepted and condition false -> no output change, stay IDLE.
  - FLUSH: flush=1, br_busy=1 throughout. MP=1 only in the first FLUSH cycle. Each non-stalled cycle: if counter==0 -> IDLE (flush, br_busy drop next cycle), else counter decrements. br_valid is ignored: no evaluation and no MP.
- Latency: branch accepted at edge k -> MP and flush high during cycle k+1. flush stays high for exactly FLUSH_CYCLES non-stalled cycles.
- Stall:
  - Counter, state and flags_q hold.
  - MP is a pulse: if stall is high during the MP cycle, MP still deasserts after one cycle.
  - flush stays high while stalled in FLUSH.
- FLUSH_CYCLES=1: flush high exactly one cycle, coincident with MP; back-to-back branches are accepted on alternate cycles.
- Reset mid-FLUSH: next cycle IDLE, MP=flush=br_busy=0, flags_q cleared.

Optional Feature:
- Macro BRANCH_STATS_EN. When defined, adds output ports br_count[CNT_W] and taken_count[CNT_W], reset to 0.
- br_count increments on every accepted branch. taken_count increments on every accepted taken branch.
- Both counters saturate at all-ones (no wrap) and hold while stalled.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset then flag_we with alu_result=0x0000 -> flags_q=4'b1000. Next cycle br_valid, BS=0 (EQ) -> MP=1 for one cycle, flush=1 for 2 cycles, br_busy=1 for 2 cycles.
- Same-cycle forwarding: flags_q=0000, same cycle flag_we, alu_result=0x8000, br_valid, BS=3 (LTZ) -> MP=1 next cycle, flags_q=0100.
- Signed/unsigned compares: flags Z=0,N=1,V=1 with BS=10 (GT) -> taken. Flags C=1,Z=1 with BS=14 (HI) -> not taken, flush stays 0. BS=4 always not taken; BS=5 always taken.
- Stall in FLUSH: taken branch, stall=1 for 3 cycles on first FLUSH cycle -> MP high 1 cycle only, flush high 2+3=5 cycles total. br_valid with BS=5 during FLUSH -> ignored.
- Reset mid-FLUSH: assert rst in first FLUSH cycle -> next cycle MP=flush=br_busy=0, flags_q=0. A branch with BS=5 right after reset is accepted normally.
- With BRANCH_STATS_EN and CNT_W=2: 5 accepted taken branches -> br_count=taken_count=3 (saturated). 1 not-taken branch -> counts unchanged at 3.
